// File: rtl/mips_mem_pkg.sv
// Shared types and address-decode helper for the mips memory responder.
package mips_mem_pkg;

  typedef enum logic {MEM_RUN, MEM_LOAD} mem_state_t;

  // Returns {in_range, 2'b00, word offset[29:0]}; callers slice the index bits they need.
  function automatic logic [32:0] mem_index(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
    logic [31:0] off;
    logic [33:0] span;
    off  = addr - base;
    span = {depth, 2'b00};
    return {({2'b00, off} < span), 2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Shared word array: one sync write port, async instruction read, registered data read.
module mips_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] instr_idx,
  output logic [31:0]   instr_data,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign instr_data = mem[instr_idx];

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? 32'h0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the mips core with program loader; optional access checking
// enabled by defining MIPS_MEM_ACCESS_CHECK_EN.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  input  logic        data_rd_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        load_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        core_hold,
  output logic [31:0] load_count,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  logic [32:0]   instr_map, data_map, load_map;
  logic          instr_in, data_in, load_in;
  logic [AW-1:0] instr_idx, data_idx, load_idx;
  logic          unused_map_bits;

  assign instr_map = mem_index(instr_addr, BASE_ADDR, DEPTH32);
  assign data_map  = mem_index(data_addr, BASE_ADDR, DEPTH32);
  assign load_map  = mem_index(load_addr, BASE_ADDR, DEPTH32);
  assign instr_in  = instr_map[32];
  assign data_in   = data_map[32];
  assign load_in   = load_map[32];
  assign instr_idx = instr_map[AW-1:0];
  assign data_idx  = data_map[AW-1:0];
  assign load_idx  = load_map[AW-1:0];
  assign unused_map_bits = ^{instr_map[31:AW], data_map[31:AW], load_map[31:AW]};

  mem_state_t  state_reg, state_next;
  logic [31:0] load_count_reg, load_count_next;
  logic        run_access, load_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= MEM_RUN;
      load_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      load_count_reg <= load_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    load_count_next = load_count_reg;
    load_ready      = 1'b0;
    core_hold       = 1'b0;
    run_access      = 1'b0;
    load_hs         = 1'b0;
    case (state_reg)
      MEM_RUN: begin
        run_access = 1'b1;
        if (load_start) begin
          state_next      = MEM_LOAD;
          load_count_next = '0;
        end
      end
      MEM_LOAD: begin
        load_ready = 1'b1;
        core_hold  = 1'b1;
        load_hs    = load_valid;
        if (load_valid) begin
          load_count_next = load_count_reg + 32'd1;
          if (load_last) state_next = MEM_RUN;
        end
      end
      default: state_next = MEM_RUN;
    endcase
  end

  assign load_count = load_count_reg;

  // Loader owns the write port in LOAD; the core owns it in RUN.
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_irdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = data_idx;
    mem_wdata = data_wdata;
    if (load_hs) begin
      mem_we    = load_in & ~reset;
      mem_widx  = load_idx;
      mem_wdata = load_data;
    end else if (run_access && !data_rd_wr) begin
      mem_we = data_in & ~reset;
    end
  end

  mips_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk        (clk),
    .reset      (reset),
    .we         (mem_we),
    .wr_idx     (mem_widx),
    .wr_data    (mem_wdata),
    .instr_idx  (instr_idx),
    .instr_data (mem_irdata),
    .rd_en      (run_access & data_rd_wr),
    .rd_zero    (~data_in),
    .rd_idx     (data_idx),
    .rd_data    (data_rdata)
  );

  assign instr_rdata = instr_in ? mem_irdata : 32'h0;

`ifdef MIPS_MEM_ACCESS_CHECK_EN
  logic        err_reg;
  logic [31:0] err_addr_reg;
  logic        run_bad, load_bad;

  assign run_bad  = run_access & (~data_in | (|data_addr[1:0]));
  assign load_bad = load_hs & (~load_in | (|load_addr[1:0]));

  // First offender wins; the flag stays up until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else if (!err_reg && (run_bad || load_bad)) begin
      err_reg      <= 1'b1;
      err_addr_reg <= run_bad ? data_addr : load_addr;
    end
  end

  assign err      = err_reg;
  assign err_addr = err_addr_reg;
`else
  assign err      = 1'b0;
  assign err_addr = 32'h0;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: data reads queue their expected word at issue.
module tb_mips_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8002_0000;

`ifdef MIPS_MEM_ACCESS_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_rd_wr;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        load_start, load_valid, load_ready, load_last;
  logic [31:0] load_addr, load_data, load_count;
  logic        core_hold, err;
  logic [31:0] err_addr;

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .data_rd_wr(data_rd_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .core_hold(core_hold), .load_count(load_count),
    .err(err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    data_rd_wr = 1'b1;
    data_addr  = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    $display("rd   addr %h data %h", addr, data_rdata);
    check(t, data_rdata, e);
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] wdata);
    data_rd_wr = 1'b0;
    data_addr  = addr;
    data_wdata = wdata;
    tick();
    data_rd_wr = 1'b1;
    $display("wr   addr %h data %h", addr, wdata);
  endtask

  task automatic handshake(input logic [31:0] addr, input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_last  = last;
    check("hold_at_hs", {31'b0, core_hold}, 32'd1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    $display("load addr %h data %h last %0d", addr, data, last);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    instr_addr = addr;
    #1;
    check(tag, instr_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; instr_addr = BASE; data_rd_wr = 1'b1; data_addr = BASE;
    data_wdata = '0; load_start = 1'b0; load_valid = 1'b0; load_addr = BASE;
    load_data = '0; load_last = 1'b0;
    tick(); tick();
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_hold", {31'b0, core_hold}, 32'd0);
    check("rst_count", load_count, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;

    // 1: store then load; instruction port sees the store next cycle
    instr_addr = BASE + 32'h10;
    drive_write(BASE + 32'h10, 32'hDEAD_BEEF);
    check("instr_after_sw", instr_rdata, 32'hDEAD_BEEF);
    drive_write(BASE + 32'h200, 32'h1234_5678);
    drive_read(BASE + 32'h10, 32'hDEAD_BEEF, "lw_deadbeef");

    // 2: gapped loader burst
    pulse_start();
    check("load_ready", {31'b0, load_ready}, 32'd1);
    check("load_cnt0", load_count, 32'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (k) tick();
      handshake(BASE + 32'(4 * k), 32'(k + 1), k == 3);
      if (k == 1) check("load_cnt2", load_count, 32'd2);
    end
    check("hold_after", {31'b0, core_hold}, 32'd0);
    check("ready_after", {31'b0, load_ready}, 32'd0);
    check("load_cnt4", load_count, 32'd4);
    for (int k = 0; k < 4; k++) fetch(BASE + 32'(4 * k), 32'(k + 1), "fetch_loaded");

    // 3: data port ignored while loading
    drive_read(BASE + 32'h10, 32'hDEAD_BEEF, "lw_before_load");
    pulse_start();
    drive_read(BASE, 32'hDEAD_BEEF, "rdata_holds");
    drive_write(BASE, 32'h55);
    handshake(BASE + 32'h100, 32'hAB, 1'b1);
    fetch(BASE, 32'h1, "no_wr_in_load");
    drive_read(BASE, 32'h1, "lw_after_load");

    // 6: start and valid together in RUN
    load_start = 1'b1; load_valid = 1'b1; load_addr = BASE + 32'h200;
    load_data = 32'h66; load_last = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    check("same_cyc_cnt", load_count, 32'd0);
    check("same_cyc_hold", {31'b0, core_hold}, 32'd1);
    fetch(BASE + 32'h200, 32'h1234_5678, "same_cyc_nowr");
    handshake(BASE + 32'h204, 32'h77, 1'b1);
    check("same_cyc_cnt1", load_count, 32'd1);
    fetch(BASE + 32'h204, 32'h77, "fetch_77");

    // 4: out-of-range and misaligned accesses
    check("err_clean", {31'b0, err}, 32'd0);
    drive_read(32'h7FFF_FFFC, 32'h0, "oor_read");
    check("err_set", {31'b0, err}, {31'b0, EXP_ERR});
    check("err_addr", err_addr, EXP_ERR ? 32'h7FFF_FFFC : 32'h0);
    drive_write(BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0);
    fetch(BASE, 32'h1, "oor_wr_dropped");
    fetch(32'h7FFF_FFFC, 32'h0, "instr_oor");
    drive_read(BASE + 32'h2, 32'h1, "misaligned_rd");
    data_addr = BASE;
    check("err_addr_keep", err_addr, EXP_ERR ? 32'h7FFF_FFFC : 32'h0);

    // 5: reset in the middle of a load
    pulse_start();
    handshake(BASE + 32'h300, 32'hA0, 1'b0);
    handshake(BASE + 32'h304, 32'hA1, 1'b0);
    check("mid_cnt2", load_count, 32'd2);
    reset = 1'b1;
    tick();
    check("mid_rst_hold", {31'b0, core_hold}, 32'd0);
    check("mid_rst_ready", {31'b0, load_ready}, 32'd0);
    check("mid_rst_cnt", load_count, 32'd0);
    check("mid_rst_rdata", data_rdata, 32'h0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    check("mid_rst_erra", err_addr, 32'h0);
    reset = 1'b0;
    fetch(BASE + 32'h300, 32'hA0, "kept_w0");
    fetch(BASE + 32'h304, 32'hA1, "kept_w1");
    drive_read(BASE + 32'h304, 32'hA1, "lw_kept_w1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
